// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell, LSB first.
// A START accepted in IDLE or FIN loads the operands; WIDTH SHIFT cycles
// later the result appears in FIN with a one-cycle DONE pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a SUB input that turns the
// operation into A-B (C_OUT=1 then means no borrow).
module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sum_bit;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Operand and initial carry selection at load time.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = SUB ? ~B : B;
  assign w_c_load = SUB ? 1'b1 : C_IN;
`else
  assign w_b_load = B;
  assign w_c_load = C_IN;
`endif

  // START is only honoured outside SHIFT; an operation cannot be aborted.
  assign w_accept = START && (r_state != SHIFT);
  assign w_last   = (r_cnt == LAST);

  // The single full-adder cell working on the current LSB pair.
  assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_out = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  assign BUSY = (r_state == SHIFT);
  assign DONE = (r_state == FIN);

  // State register with synchronous reset.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: SHIFT runs until the counter reaches WIDTH-1.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (START) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = FIN;
      FIN:     w_next = START ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one bit per SHIFT cycle, flags on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      SUM     <= '0;
      C_OUT   <= 1'b0;
      OVF     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_out;
      SUM     <= {w_sum_bit, SUM[WIDTH-1:1]};
      if (w_last) begin
        // r_carry is the carry into the MSB during this final bit.
        C_OUT <= w_carry_out;
        OVF   <= r_carry ^ w_carry_out;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; legal range 2..64.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: START  input  1  request to begin an addition; sampled on rising edge.
REQ-005 SHALL have port: A  input  WIDTH  first operand; sampled only when START is accepted.
REQ-006 SHALL have port: B  input  WIDTH  second operand; sampled only when START is accepted.
REQ-007 SHALL have port: C_IN  input  1  carry-in; sampled only when START is accepted.
REQ-008 SHALL have port: SUM  output  WIDTH  result register.
REQ-009 SHALL have port: C_OUT  output  1  final carry-out.
REQ-010 SHALL have port: OVF  output  1  signed overflow flag: carry into MSB XOR C_OUT.
REQ-011 SHALL have port: BUSY  output  1  high while bits are being processed.
REQ-012 SHALL have port: DONE  output  1  one-cycle pulse marking SUM, C_OUT and OVF valid.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and FIN.
REQ-014 SHALL accept START in IDLE or FIN only: load the A and B shift registers, set the carry flip-flop to C_IN, clear the bit counter, and enter SHIFT.
REQ-015 SHALL ignore START while in SHIFT; there is no abort or restart.
REQ-016 SHALL, in each SHIFT cycle, process one bit pair LSB-first through one full-adder cell:
  - shift the sum bit into SUM from the MSB side;
  - register the carry;
  - increment the counter.
REQ-017 SHALL leave SHIFT after exactly WIDTH cycles and enter FIN; the counter SHALL NOT wrap inside SHIFT.
REQ-018 SHALL capture the carry into the MSB position during the last SHIFT cycle for OVF.
REQ-019 SHALL, in FIN, assert DONE for exactly one cycle and then go to IDLE, unless START is accepted in that same cycle.
REQ-020 SHALL hold SUM, C_OUT and OVF stable from FIN until the next accepted START.
REQ-021 SHALL give a latency of WIDTH+1 cycles from the START-sampling edge to the DONE-high cycle.
REQ-022 SHALL assert BUSY exactly while the state is SHIFT.
REQ-023 SHALL never assert DONE and BUSY in the same cycle.
REQ-024 SHALL discard any carry beyond C_OUT; the result is a sum modulo 2^WIDTH plus C_OUT.
REQ-025 SHALL, on START accepted in FIN, pulse DONE in that cycle and then enter SHIFT, giving back-to-back operations.

Reset
REQ-026 SHALL, when RST=1 at a rising edge, force state IDLE and clear all of SUM, C_OUT, OVF, BUSY, DONE, the counter and the carry, regardless of state.
REQ-027 SHALL give RST priority over START; an operation interrupted mid-SHIFT is lost and no DONE is produced.

Configuration
REQ-028 SHALL support macro SERIAL_ADDER_SUB_EN.
REQ-029 SHALL, with SERIAL_ADDER_SUB_EN defined:
  - add port SUB  input  1, sampled with START;
  - when SUB=1, load ~B and set the initial carry to 1, ignoring C_IN, so the result is A-B;
  - C_OUT=1 then means no borrow.
REQ-030 SHALL, with SERIAL_ADDER_SUB_EN undefined, have no SUB port and support addition only.

Verification
REQ-031 SHALL cover: WIDTH=32, A=0x00000005, B=0x00000003, C_IN=0, START one cycle -> BUSY for 32 cycles, DONE at START+33, SUM=0x00000008, C_OUT=0, OVF=0.
REQ-032 SHALL cover: A=0xFFFFFFFF, B=0x00000001, C_IN=0 -> SUM=0x00000000, C_OUT=1, OVF=0.
REQ-033 SHALL cover: A=0x7FFFFFFF, B=0x00000000, C_IN=1 -> SUM=0x80000000, C_OUT=0, OVF=1.
REQ-034 SHALL cover: START pulsed again mid-SHIFT with different operands -> ignored; first result still SUM=0x00000008; START held in the FIN cycle -> second result follows 33 cycles later.
REQ-035 SHALL cover: RST asserted at SHIFT cycle 10 -> next cycle all outputs 0, state IDLE, no DONE pulse; a fresh START then completes normally.
REQ-036 SHALL cover, with SERIAL_ADDER_SUB_EN: A=0x00000003, B=0x00000005, SUB=1 -> SUM=0xFFFFFFFE, C_OUT=0, OVF=0.
